// File: rtl/seq_multiplier_if.sv
// Operand/result bundle for the sequential multiplier. The master issues
// start with the operands. The slave (the multiplier) answers with busy,
// done and product.
//
// Handshake: the master raises start for one or more cycles. The slave
// captures signed_mode/op_a/op_b on the first rising edge where start=1
// and busy=0. From that edge until the edge that writes product, busy
// stays high and start is ignored. done pulses for one cycle when product
// is updated. A start raised during that done cycle is accepted.
interface seq_multiplier_if #(
  parameter int WIDTH = 32
) ();
  logic                   start;
  logic                   signed_mode;
  logic [WIDTH-1:0]       op_a;
  logic [WIDTH-1:0]       op_b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;
  logic                   state_dbg;

  modport master (
    output start, signed_mode, op_a, op_b,
    input  busy, done, product, state_dbg
  );

  modport slave (
    input  start, signed_mode, op_a, op_b,
    output busy, done, product, state_dbg
  );
endinterface

// File: rtl/seq_multiplier.sv
// Shift-and-add multiplier that performs one partial-product add per clock.
// Signed operands are reduced to magnitudes at capture. The sign is put back
// on the finishing edge by negating the 2*WIDTH-bit accumulator.
// With EARLY_EXIT set, the run ends as soon as the remaining multiplier bits
// are all zero.
module seq_multiplier #(
  parameter int WIDTH      = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input logic             clk,
  input logic             reset,
  seq_multiplier_if.slave bus
);

  localparam int             CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  COUNT_LAST = CW'(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state;
  logic [2*WIDTH-1:0]     acc;
  logic [2*WIDTH-1:0]     a_sh;
  logic [WIDTH-1:0]       b_sh;
  logic [CW-1:0]          count;
  logic                   neg;

  logic [WIDTH-1:0]       mag_a;
  logic [WIDTH-1:0]       mag_b;
  logic                   finish;

  // The most negative value negates to itself. Read as unsigned, that
  // pattern is the correct magnitude 2^(WIDTH-1).
  always_comb begin
    mag_a = (bus.signed_mode && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
    mag_b = (bus.signed_mode && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
  end

  // The run ends after WIDTH iterations, or earlier once no multiplier bits remain.
  always_comb begin
    finish = (count == COUNT_LAST) || (EARLY_EXIT && (b_sh == '0));
  end

  assign bus.state_dbg = (state == RUN);

  // Control FSM and datapath. Capture happens in IDLE and iterations in RUN.
  // The finishing edge only writes the result and performs no add.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      count       <= '0;
      neg         <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.product <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc      <= '0;
            count    <= '0;
            a_sh     <= {{WIDTH{1'b0}}, mag_a};
            b_sh     <= mag_b;
            neg      <= bus.signed_mode & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (finish) begin
            bus.product <= neg ? -acc : acc;
            bus.done    <= 1'b1;
            bus.busy    <= 1'b0;
            state       <= IDLE;
          end else begin
            if (b_sh[0]) begin
              acc <= acc + a_sh;
            end
            a_sh  <= a_sh << 1;
            b_sh  <= b_sh >> 1;
            count <= count + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier. It drives two instances, one with early exit and
// one that always runs WIDTH iterations. Every issued operation pushes its
// expected product, completion cycle and busy length into a per-instance
// queue. A negedge monitor pops and compares each done pulse.
module tb_seq_multiplier;

  typedef struct {
    logic [63:0] prod;
    int          done_cyc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_d       [2];
  logic        start_d     [2];
  logic        sm_d        [2];
  logic [31:0] op_a_d      [2];
  logic [31:0] op_b_d      [2];
  logic        busy_s      [2];
  logic        done_s      [2];
  logic        state_s     [2];
  logic [63:0] prod_s      [2];

  exp_t        exp_q[2][$];
  int          busy_run    [2];
  int          cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  seq_multiplier_if #(.WIDTH(32)) bus0 ();
  seq_multiplier_if #(.WIDTH(32)) bus1 ();

  assign bus0.start       = start_d[0];
  assign bus0.signed_mode = sm_d[0];
  assign bus0.op_a        = op_a_d[0];
  assign bus0.op_b        = op_b_d[0];
  assign busy_s[0]        = bus0.busy;
  assign done_s[0]        = bus0.done;
  assign prod_s[0]        = bus0.product;
  assign state_s[0]       = bus0.state_dbg;

  assign bus1.start       = start_d[1];
  assign bus1.signed_mode = sm_d[1];
  assign bus1.op_a        = op_a_d[1];
  assign bus1.op_b        = op_b_d[1];
  assign busy_s[1]        = bus1.busy;
  assign done_s[1]        = bus1.done;
  assign prod_s[1]        = bus1.product;
  assign state_s[1]       = bus1.state_dbg;

  seq_multiplier #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut_ee (
    .clk   (clk),
    .reset (rst_d[0]),
    .bus   (bus0)
  );

  seq_multiplier #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut_ne (
    .clk   (clk),
    .reset (rst_d[1]),
    .bus   (bus1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Full product from plain integer arithmetic.
  // Latency: 1 edge plus the bit length of |op_b| with early exit, otherwise WIDTH+1.
  function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic sm, bit ee);
    exp_t   e;
    longint sa, sb;
    int     n;
    if (sm) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    e.prod = 64'(sa * sb);
    if (sb < 0) sb = -sb;
    n = 0;
    while ((sb >> n) != 0) n++;
    e.lat      = ee ? n + 1 : 33;
    e.done_cyc = 0;
    return e;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_idle(int d);
    int guard = 0;
    while (busy_s[d] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (busy_s[d]) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: dut %0d still busy after %0d cycles", d, guard);
    end
  endtask

  // Issue one operation with an explicitly given expectation.
  task automatic issue_exp(int d, logic [31:0] a, logic [31:0] b, logic sm,
                           logic [63:0] p, int lat);
    exp_t e;
    wait_idle(d);
    start_d[d] = 1'b1;
    op_a_d[d]  = a;
    op_b_d[d]  = b;
    sm_d[d]    = sm;
    e.prod     = p;
    e.lat      = lat;
    e.done_cyc = cyc + 1 + lat;
    exp_q[d].push_back(e);
    @(negedge clk);
    start_d[d] = 1'b0;
    op_a_d[d]  = $urandom;
    op_b_d[d]  = $urandom;
    sm_d[d]    = 1'($urandom_range(0, 1));
  endtask

  // Issue one operation with its expectation taken from the model.
  task automatic issue(int d, logic [31:0] a, logic [31:0] b, logic sm);
    exp_t e;
    e = model(a, b, sm, d == 0);
    issue_exp(d, a, b, sm, e.prod, e.lat);
  endtask

  // Raise start with junk operands while the unit is busy.
  task automatic poke(int d);
    chk("poke_busy", 64'(busy_s[d]), 64'd1);
    chk("poke_state_run", 64'(state_s[d]), 64'd1);
    start_d[d] = 1'b1;
    op_a_d[d]  = $urandom;
    op_b_d[d]  = $urandom;
    sm_d[d]    = 1'($urandom_range(0, 1));
    @(negedge clk);
    start_d[d] = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_d[d]) begin
        if (busy_s[d]) busy_run[d]++;
        if (done_s[d]) begin
          if (exp_q[d].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: dut %0d product %h", d, prod_s[d]);
          end else begin
            exp_t e;
            e = exp_q[d].pop_front();
            chk("product", prod_s[d], e.prod);
            chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
            chk("busy_cycles", 64'(busy_run[d]), 64'(e.lat));
          end
          busy_run[d] = 0;
        end else if (exp_q[d].size() > 0 && cyc > exp_q[d][0].done_cyc) begin
          checks++;
          errors++;
          $display("FAIL done_timeout: dut %0d expected done at %0d, now %0d",
                   d, exp_q[d][0].done_cyc, cyc);
          void'(exp_q[d].pop_front());
          busy_run[d] = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_d[d]    = 1'b1;
      start_d[d]  = 1'b0;
      sm_d[d]     = 1'b0;
      op_a_d[d]   = '0;
      op_b_d[d]   = '0;
      busy_run[d] = 0;
    end
    repeat (3) @(negedge clk);
    rst_d[0] = 1'b0;
    rst_d[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_busy", 64'(busy_s[d]), 64'd0);
      chk("reset_done", 64'(done_s[d]), 64'd0);
      chk("reset_product", prod_s[d], 64'd0);
      chk("reset_state", 64'(state_s[d]), 64'd0);
    end

    // Directed cases with hand-computed results and latencies.
    issue_exp(0, 32'd78319, 32'd54491, 1'b0, 64'd4267680629, 17);
    issue_exp(0, 32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 4);
    issue_exp(0, 32'hFFFF_FFFD, 32'd7, 1'b0, 64'h0000_0006_FFFF_FFEB, 4);
    issue_exp(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 33);
    issue_exp(0, 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 33);
    issue_exp(0, 32'd12345, 32'd0, 1'b0, 64'd0, 1);
    issue_exp(1, 32'd5, 32'd3, 1'b0, 64'd15, 33);
    issue_exp(1, 32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 33);

    // A start during RUN is ignored. A start during the done cycle is taken.
    issue_exp(0, 32'd1000, 32'd300, 1'b0, 64'd300000, 10);
    poke(0);
    poke(0);
    wait_idle(0);
    chk("start_in_done_cycle", 64'(done_s[0]), 64'd1);
    issue_exp(0, 32'd6, 32'd7, 1'b0, 64'd42, 4);

    // Asynchronous reset between edges aborts the run without a done pulse.
    issue_exp(0, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 64'h0000_0000_FFFE_0001, 17);
    repeat (5) @(negedge clk);
    #2 rst_d[0] = 1'b1;
    #1;
    chk("async_reset_busy", 64'(busy_s[0]), 64'd0);
    chk("async_reset_done", 64'(done_s[0]), 64'd0);
    chk("async_reset_product", prod_s[0], 64'd0);
    exp_q[0].delete();
    busy_run[0] = 0;
    @(negedge clk);
    @(negedge clk);
    rst_d[0] = 1'b0;
    @(negedge clk);
    issue_exp(0, 32'd9, 32'd9, 1'b0, 64'd81, 5);

    // Randomized operations on both instances, checked against the model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic        sm;
      a  = $urandom;
      sm = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       b = $urandom & 32'h0000_00FF;
        1:       b = $urandom;
        2:       b = 32'($urandom_range(0, 1));
        default: b = 32'h8000_0000 | ($urandom & 32'h0000_000F);
      endcase
      issue(i % 2, a, b, sm);
    end

    // Drain both scoreboards.
    for (int g = 0; g < 200 && (exp_q[0].size() + exp_q[1].size()) > 0; g++) begin
      @(negedge clk);
    end
    if ((exp_q[0].size() + exp_q[1].size()) > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding", exp_q[0].size() + exp_q[1].size());
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised sequential shift-and-add multiplier. It computes the full 2*WIDTH-bit product of two WIDTH-bit operands, in signed or unsigned mode selected per operation. A start/busy/done handshake, operand capture and optional early termination make it usable as the integer multiply unit feeding the FPU mantissa datapath. One partial-product add is performed per clock.

Parameters:
WIDTH, 32, operand width in bits (>= 2); product is 2*WIDTH bits
EARLY_EXIT, 1, 1 = finish as soon as the remaining multiplier bits are all zero; 0 = always run WIDTH iterations

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high; clears all state
start  input  1  request; sampled only when busy=0
signed_mode  input  1  1 = two's-complement operands/product; captured with start
op_a  input  WIDTH  multiplicand; captured with start
op_b  input  WIDTH  multiplier; captured with start
busy  output  1  high from the capture edge until the edge that writes product
done  output  1  one-cycle pulse: product valid and updated this cycle
product  output  2*WIDTH  result register; holds its value until the next completion

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, busy=0, done=0, product=0, all internal registers 0. An aborted operation never raises done.
- States:
  - IDLE: busy=0. At an edge where start=1, capture the operands and go to RUN.
  - RUN: busy=1. Perform one iteration per edge, then go to IDLE when complete.
- Capture:
  - signed_mode=1: mag_a=|op_a|, mag_b=|op_b|, neg=op_a[W-1]^op_b[W-1].
  - signed_mode=0: mag=raw operand, neg=0.
  - |-2^(W-1)| = 2^(W-1), which is representable as an unsigned W-bit value.
  - acc=0, count=0, a_sh=zero-extended mag_a (2W bits), b_sh=mag_b.
- RUN iteration edge, when not finishing:
  - if b_sh[0], acc += a_sh (2W-bit add; no overflow possible)
  - a_sh <<= 1; b_sh >>= 1; count++
- Finish condition, evaluated at each RUN edge before iterating: count==WIDTH, or (EARLY_EXIT and b_sh==0). On the finishing edge:
  - product <= neg ? -acc : acc (2W-bit two's complement)
  - done <= 1, busy <= 0, state <= IDLE
  - no add is performed on this edge
- Latency, measured in edges after the capture edge: N+1, where N=WIDTH if EARLY_EXIT=0. Otherwise N = index of the highest set bit of mag_b, plus 1; mag_b=0 gives N=0, i.e. 1 edge.
- done is high for exactly one cycle. It is deasserted on the next edge unless another completion occurs.
- start while busy=1 is ignored: no re-capture, no effect on the result.
- start during the done cycle is accepted, since state is IDLE. Back-to-back operations are allowed with no gap cycle.
- Operand inputs are don't-care except at the capture edge.

Test Plan:
- Unsigned, EARLY_EXIT=1: op_a=78319, op_b=54491 -> product=4267680629; done exactly 17 edges after capture; busy high for those 17 cycles.
- Signed: op_a=-3 (32'hFFFFFFFD), op_b=7 -> product=64'hFFFF_FFFF_FFFF_FFEB (-21); done 4 edges after capture. Repeat with signed_mode=0 -> product=64'h0000_0006_FFFF_FFEB.
- Extremes: unsigned 32'hFFFFFFFF*32'hFFFFFFFF -> 64'hFFFF_FFFE_0000_0001. Signed 32'h80000000*32'h80000000 -> 64'h4000_0000_0000_0000. Both complete in 33 edges.
- Zero and no-early-exit: op_b=0 -> product=0, done 1 edge after capture. With EARLY_EXIT=0, op_a=5, op_b=3 -> product=15, done at 33 edges.
- Handshake: pulse start with new operands mid-RUN -> ignored, first result unaffected. Assert start in the done cycle with 6*7 -> second capture on that edge, product=42 after 4 more edges.
- Reset mid-RUN (asynchronous, between edges) -> busy/done/product drop to 0 immediately, no done pulse. A following operation 9*9=81 completes normally.
